// File: rtl/handshake_constant_seq_pkg.sv
// Shared handshake definitions: constant-table mode encodings, the token
// buffer depth and the occupancy encoding used by the skid buffer.
package handshake_constant_seq_pkg;

  // Encodings for the CYCLE_MODE parameter of handshake_constant_seq.
  localparam int CONST_MODE_FIXED = 0;
  localparam int CONST_MODE_CYCLE = 1;

  // Number of tokens the output buffer can hold.
  localparam int FIFO_DEPTH = 2;

  // Buffer fill level; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'(FIFO_DEPTH)
  } occ_e;

  // Index register width: enough bits for NUM_CONSTS entries, never zero.
  function automatic int idx_width(input int num_consts);
    return (num_consts > 1) ? $clog2(num_consts) : 1;
  endfunction

endpackage

// File: rtl/handshake_skid_buffer.sv
// Two-entry token FIFO with a valid/ready handshake on both sides.
// in_ready depends only on registered state and rst, so the consumer's
// outs_ready never reaches the producer combinationally.
module handshake_skid_buffer
  import handshake_constant_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  occ_e                  occ;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  enq;
  logic                  deq;

  assign in_ready  = (occ != OCC_FULL) && !rst;
  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = head;
  assign occupancy = occ;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  // Head always holds the oldest token; tail is used only when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (enq) begin
            head <= in_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (enq && deq) begin
            head <= in_data;
          end else if (enq) begin
            tail <= in_data;
            occ  <= OCC_FULL;
          end else if (deq) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (deq) begin
            head <= tail;
            occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one constant from CONST_TABLE per accepted control token, either
// always entry 0 or cycling round-robin through the table. Tokens are
// buffered in a two-entry skid buffer so ctrl_ready is fully registered.
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                               DATA_WIDTH  = 32,
  parameter int                               NUM_CONSTS  = 4,
  parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = '0,
  parameter int                               CYCLE_MODE  = CONST_MODE_CYCLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [1:0]            occupancy
);

  localparam int               IDX_W    = idx_width(NUM_CONSTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSTS - 1);
  localparam bit               ADVANCE  = (CYCLE_MODE == CONST_MODE_CYCLE) && (NUM_CONSTS > 1);

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] token;
  logic                  accept;

  assign accept = ctrl_valid && ctrl_ready;

  // Table lookup as an explicit mux so idx can never select past the table.
  always_comb begin
    token = '0;
    for (int i = 0; i < NUM_CONSTS; i++) begin
      if (idx == IDX_W'(i)) begin
        token = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Index counter: restart takes priority over the per-accept advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (restart) begin
      idx <= '0;
    end else if (accept && ADVANCE) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  handshake_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (token),
    .in_valid  (ctrl_valid),
    .in_ready  (ctrl_ready),
    .out_data  (outs),
    .out_valid (outs_valid),
    .out_ready (outs_ready),
    .occupancy (occupancy)
  );

endmodule

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of each constant and of outs.
REQ-002 Parameter NUM_CONSTS, default 4, sets the number of table entries; legal range is 1..256.
REQ-003 Parameter CONST_TABLE, width NUM_CONSTS*DATA_WIDTH, default all-zero, holds entry i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-004 Parameter CYCLE_MODE, default 1: 0 = always emit entry 0; 1 = emit entries round-robin.
REQ-005 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, is the reset; it is asynchronous and active-high.
REQ-007 Port restart, input, 1 bit, synchronously returns the table index to 0.
REQ-008 Port ctrl_valid, input, 1 bit, indicates that a control token is offered.
REQ-009 Port ctrl_ready, output, 1 bit, indicates that the block accepts a control token.
REQ-010 Port outs, output, DATA_WIDTH bits, carries the emitted constant.
REQ-011 Port outs_valid, output, 1 bit, indicates that outs holds a token.
REQ-012 Port outs_ready, input, 1 bit, indicates that the consumer accepts the token.
REQ-013 Port occupancy, output, 2 bits, gives the number of buffered tokens (0..2).

Function
REQ-014 A control transfer shall occur on a clock edge where ctrl_valid=1 and ctrl_ready=1; an output transfer shall occur on an edge where outs_valid=1 and outs_ready=1.
REQ-015 Each control transfer shall enqueue exactly one token equal to CONST_TABLE entry idx, where idx is the index value before that edge.
REQ-016 In CYCLE_MODE=1, idx shall advance by 1 on each control transfer and wrap from NUM_CONSTS-1 to 0; in CYCLE_MODE=0 (or when NUM_CONSTS=1), idx shall remain 0.
REQ-017 The index register shall be max(1, clog2(NUM_CONSTS)) bits wide and shall never hold a value of NUM_CONSTS or greater.
REQ-018 Tokens shall be held in a 2-entry FIFO; outs_valid shall be 1 when occupancy>0, and outs shall show the oldest entry.
REQ-019 ctrl_ready shall be 1 exactly when occupancy<2 and rst=0; it shall have no combinational path from outs_ready or outs_valid.
REQ-020 Latency: a token accepted at edge N shall be valid on outs after edge N, with no combinational path from ctrl_valid to outs_valid.
REQ-021 While outs_valid=1 and outs_ready=0, outs shall stay stable and outs_valid shall stay asserted.
REQ-022 A simultaneous enqueue and dequeue shall leave occupancy unchanged and preserve order; at occupancy 1 the new token becomes the head on the next cycle.
REQ-023 When occupancy=2, no enqueue shall occur (ctrl_ready=0); a dequeue shall bring occupancy to 1, and ctrl_ready shall be 1 on the next cycle.
REQ-024 When restart=1 at an edge that also has a control transfer, the token shall use the old idx and idx shall then be 0 (restart wins over the advance).
REQ-025 restart shall not affect FIFO contents or occupancy.
REQ-026 With sustained ctrl_valid=1 and outs_ready=1, throughput shall be one token per cycle.

Reset
REQ-027 While rst=1, the block shall set occupancy=0, outs_valid=0, ctrl_ready=0, outs=0 and idx=0, asynchronously.
REQ-028 On the first edge after rst deasserts, ctrl_ready shall be 1.
REQ-029 Reset during operation shall discard all buffered tokens; no token shall appear after reset release unless a new control transfer occurs.

Structure
REQ-030 The CYCLE_MODE encodings (CONST_MODE_FIXED=0, CONST_MODE_CYCLE=1) and the FIFO depth constant (2) shall live in the shared handshake package.
REQ-031 The 2-entry FIFO shall be a separate sub-module, handshake_skid_buffer, parameterised by DATA_WIDTH.
REQ-032 The top level shall contain only the index counter, table selection and restart logic.

Verification
(All scenarios use DATA_WIDTH=17, NUM_CONSTS=3, table {0x1EBE5, 0x00001, 0x1FFFF}.)
REQ-033 Cycle mode, outs_ready=1, ctrl_valid=1 for 4 cycles -> outs shall be 0x1EBE5, 0x00001, 0x1FFFF, 0x1EBE5 on consecutive cycles, one cycle after each accept.
REQ-034 Backpressure: outs_ready=0, 3 tokens offered -> 2 accepted, occupancy=2, ctrl_ready=0, outs held at 0x1EBE5; then outs_ready=1 -> 0x1EBE5, 0x00001 drained in order.
REQ-035 Simultaneous events: occupancy=1 with enqueue and dequeue on the same edge -> occupancy stays 1 and the next outs is the newly enqueued entry.
REQ-036 Restart coincident with an accept at idx=1 -> the emitted token is 0x00001, and the next accept emits 0x1EBE5.
REQ-037 CYCLE_MODE=0, 5 accepts -> all five outputs are 0x1EBE5.
REQ-038 rst asserted with occupancy=2, mid-cycle -> outs_valid drops immediately, and after release: occupancy=0, ctrl_ready=1, and the first token is 0x1EBE5.
